// File: rtl/peripheral_system_irq_pkg.sv
// -----------------------------------------------------------------------------
// peripheral_system_irq_pkg
// Shared definitions for the peripheral interrupt controller:
//   - register word addresses of the Avalon-MM slave
//   - service FSM state encoding
// No ports (package).
// -----------------------------------------------------------------------------
package peripheral_system_irq_pkg;

   localparam logic [2:0] ADDR_PENDING = 3'd0;
   localparam logic [2:0] ADDR_MASK    = 3'd1;
   localparam logic [2:0] ADDR_EDGE    = 3'd2;
   localparam logic [2:0] ADDR_ACK     = 3'd3;
   localparam logic [2:0] ADDR_RAW     = 3'd4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVICE = 2'd1,
      HOLD    = 2'd2
   } state_t;

endpackage

// File: rtl/peripheral_system_irq_prio_enc.sv
// -----------------------------------------------------------------------------
// peripheral_system_irq_prio_enc
// Combinational lowest-index priority encoder.
// Ports:
//   req    in   NUM_IRQ  request vector
//   valid  out  1        at least one request bit set
//   id     out  ID_W     index of the lowest set bit (0 when none)
// -----------------------------------------------------------------------------
module peripheral_system_irq_prio_enc #(
   parameter int NUM_IRQ = 8,
   parameter int ID_W    = 3
) (
   input  logic [NUM_IRQ-1:0] req,
   output logic               valid,
   output logic [ID_W-1:0]    id
);

   // Scan from the top down so the lowest set index is the last one written.
   always_comb begin
      valid = |req;
      id    = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (req[i]) id = ID_W'(i);
      end
   end

endmodule

// File: rtl/peripheral_system_irq_ctrl.sv
// -----------------------------------------------------------------------------
// peripheral_system_irq_ctrl
// Interrupt controller for the timer and sibling peripherals. Latches source
// events (edge or level mode per source), masks them, and presents the
// lowest-index active source to the CPU, holding it until software writes ACK.
//
// Optional build macro: IRQ_CTRL_SYNC_EN
//   defined   -> each irq_in bit passes through a 2-flop synchronizer
//   undefined -> irq_in is used directly (sources must be synchronous to clk)
//
// Ports:
//   clk         in   1        system clock
//   reset       in   1        synchronous, active-high reset
//   address     in   3        register word address
//   chipselect  in   1        slave select
//   write_n     in   1        active-low write strobe
//   writedata   in   16       write data
//   readdata    out  16       registered read data, 1-cycle latency
//   irq_in      in   NUM_IRQ  source interrupt lines (bit 0 = timer)
//   irq_out     out  1        interrupt request to the CPU
//   irq_id      out  ID_W     source in service, valid while irq_out = 1
// -----------------------------------------------------------------------------
module peripheral_system_irq_ctrl
   import peripheral_system_irq_pkg::*;
#(
   parameter int NUM_IRQ = 8,
   parameter int ID_W    = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [2:0]         address,
   input  logic               chipselect,
   input  logic               write_n,
   input  logic [15:0]        writedata,
   output logic [15:0]        readdata,
   input  logic [NUM_IRQ-1:0] irq_in,
   output logic               irq_out,
   output logic [ID_W-1:0]    irq_id
);

   logic [NUM_IRQ-1:0] irq_s;
   logic [NUM_IRQ-1:0] irq_d;
   logic [NUM_IRQ-1:0] pending;
   logic [NUM_IRQ-1:0] pending_next;
   logic [NUM_IRQ-1:0] mask;
   logic [NUM_IRQ-1:0] edge_mode;
   logic [NUM_IRQ-1:0] active;
   logic [NUM_IRQ-1:0] rise;
   logic [NUM_IRQ-1:0] clr;
   logic [NUM_IRQ-1:0] wdata;
   logic               wr;
   logic               rd;
   logic               wr_pending;
   logic               wr_mask;
   logic               wr_edge;
   logic               wr_ack;
   logic               ack_take;
   logic               win_valid;
   logic [ID_W-1:0]    winner;
   logic [15:0]        rd_val;
   state_t             state;
   state_t             state_next;

   // Upper write-data bits beyond NUM_IRQ carry no meaning.
   logic unused_wdata;
   assign unused_wdata = ^writedata;

   // Input stage
`ifdef IRQ_CTRL_SYNC_EN
   logic [NUM_IRQ-1:0] sync_q1;
   logic [NUM_IRQ-1:0] sync_q2;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= irq_in;
         sync_q2 <= sync_q1;
      end
   end

   assign irq_s = sync_q2;
`else
   assign irq_s = irq_in;
`endif

   // Bus decode
   assign wr         = chipselect & ~write_n;
   assign rd         = chipselect &  write_n;
   assign wdata      = writedata[NUM_IRQ-1:0];
   assign wr_pending = wr && (address == ADDR_PENDING);
   assign wr_mask    = wr && (address == ADDR_MASK);
   assign wr_edge    = wr && (address == ADDR_EDGE);
   assign wr_ack     = wr && (address == ADDR_ACK);
   assign ack_take   = wr_ack && (state == SERVICE);

   assign rise   = irq_s & ~irq_d;
   assign active = pending & mask;

   peripheral_system_irq_prio_enc #(
      .NUM_IRQ (NUM_IRQ),
      .ID_W    (ID_W)
   ) u_prio_enc (
      .req   (active),
      .valid (win_valid),
      .id    (winner)
   );

   // Pending update. A set in the same cycle as a clear wins so no event is
   // lost. A source being switched from level to edge mode starts empty; only
   // a genuine rise in that cycle creates an event, never a standing level.
   always_comb begin
      clr          = '0;
      pending_next = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         clr[i] = (wr_pending && wdata[i]) ||
                  (ack_take && (irq_id == ID_W'(i)));
         if (edge_mode[i])
            pending_next[i] = rise[i] | (pending[i] & ~clr[i]);
         else if (wr_edge && wdata[i])
            pending_next[i] = rise[i];
         else
            pending_next[i] = irq_s[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending   <= '0;
         mask      <= '0;
         edge_mode <= '0;
         irq_d     <= '0;
      end else begin
         pending <= pending_next;
         irq_d   <= irq_s;
         if (wr_mask) mask      <= wdata;
         if (wr_edge) edge_mode <= wdata;
      end
   end

   // Service FSM
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (win_valid) state_next = SERVICE;
         SERVICE: begin
            if (wr_ack)
               state_next = HOLD;
            else if (!active[irq_id])
               state_next = IDLE;   // source withdrew itself, no ACK needed
         end
         HOLD:    state_next = IDLE; // one idle cycle lets a level source release
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         irq_out <= 1'b0;
         irq_id  <= '0;
      end else begin
         state   <= state_next;
         irq_out <= (state_next == SERVICE);
         if (state == IDLE && win_valid) irq_id <= winner;
      end
   end

   // Read path
   always_comb begin
      rd_val = '0;
      case (address)
         ADDR_PENDING: rd_val = 16'(pending);
         ADDR_MASK:    rd_val = 16'(mask);
         ADDR_EDGE:    rd_val = 16'(edge_mode);
         ADDR_ACK:     rd_val = {irq_out, 15'(irq_id)};
         ADDR_RAW:     rd_val = 16'(irq_s);
         default:      rd_val = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)
         readdata <= '0;
      else if (rd)
         readdata <= rd_val;
   end

endmodule

// File: tb/tb_peripheral_system_irq_ctrl.sv
module tb_peripheral_system_irq_ctrl;

   localparam int NUM_IRQ = 8;
   localparam int ID_W    = 3;
`ifdef IRQ_CTRL_SYNC_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 2;
`endif

   logic               clk = 1'b0;
   logic               reset;
   logic [2:0]         address;
   logic               chipselect;
   logic               write_n;
   logic [15:0]        writedata;
   logic [15:0]        readdata;
   logic [NUM_IRQ-1:0] irq_in;
   logic               irq_out;
   logic [ID_W-1:0]    irq_id;

   int compared   = 0;
   int mismatched = 0;

   // Reference model state
   logic [7:0]  m_pend, m_mask, m_edge, m_prev, m_s1, m_s2;
   logic        m_out, m_hold;
   logic [2:0]  m_id;
   logic [15:0] m_rd;

   peripheral_system_irq_ctrl #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .irq_in     (irq_in),
      .irq_out    (irq_out),
      .irq_id     (irq_id)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] seen_input();
`ifdef IRQ_CTRL_SYNC_EN
      return m_s2;
`else
      return irq_in;
`endif
   endfunction

   // Advance the model by one clock using the inputs currently applied.
   task automatic model_step();
      logic [7:0] s, rise, act, np, clr;
      logic       wr, rd, ack;
      int         win;
      if (reset) begin
         m_pend = 0; m_mask = 0; m_edge = 0; m_prev = 0; m_s1 = 0; m_s2 = 0;
         m_out = 0; m_hold = 0; m_id = 0; m_rd = 0;
         return;
      end
      s    = seen_input();
      rise = s & ~m_prev;
      wr   = chipselect & ~write_n;
      rd   = chipselect & write_n;
      act  = m_pend & m_mask;
      ack  = wr && (address == 3) && m_out;
      clr  = 0;
      if (wr && address == 0) clr = writedata[7:0];
      if (ack) clr[m_id] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (m_edge[i])                                  np[i] = rise[i] | (m_pend[i] & ~clr[i]);
         else if (wr && address == 2 && writedata[i])    np[i] = rise[i];
         else                                            np[i] = s[i];
      end
      if (rd) begin
         case (address)
            3'd0:    m_rd = {8'h00, m_pend};
            3'd1:    m_rd = {8'h00, m_mask};
            3'd2:    m_rd = {8'h00, m_edge};
            3'd3:    m_rd = {m_out, 12'h000, m_id};
            3'd4:    m_rd = {8'h00, s};
            default: m_rd = 16'h0000;
         endcase
      end
      win = -1;
      for (int i = 0; i < 8; i++) if (act[i] && win < 0) win = i;
      if (m_out) begin
         if (ack) begin m_out = 0; m_hold = 1; end
         else if (!act[m_id]) m_out = 0;
      end else if (m_hold) begin
         m_hold = 0;
      end else if (win >= 0) begin
         m_out = 1;
         m_id  = 3'(win);
      end
      if (wr && address == 1) m_mask = writedata[7:0];
      if (wr && address == 2) m_edge = writedata[7:0];
      m_pend = np;
      m_prev = s;
      m_s2   = m_s1;
      m_s1   = irq_in;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
      chk("model_irq_out", 16'(irq_out), 16'(m_out));
      chk("model_irq_id", 16'(irq_id), 16'(m_id));
      chk("model_readdata", readdata, m_rd);
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
      address = a; chipselect = 1; write_n = 0; writedata = d;
      cyc();
      chipselect = 0; write_n = 1;
   endtask

   task automatic bus_read(input logic [2:0] a);
      address = a; chipselect = 1; write_n = 1;
      cyc();
      chipselect = 0;
   endtask

   initial begin
      reset = 1; irq_in = 0; address = 0; chipselect = 0; write_n = 1; writedata = 0;
      cyc(); cyc();
      chk("reset_irq_out", 16'(irq_out), 16'h0);
      chk("reset_irq_id", 16'(irq_id), 16'h0);
      chk("reset_readdata", readdata, 16'h0);
      reset = 0;

      // Scenario 1: single edge source
      bus_write(3'd1, 16'h0001);
      bus_write(3'd2, 16'h0001);
      irq_in = 8'h01; cyc(); irq_in = 0;
      chk("s1_not_yet", 16'(irq_out), 16'h0);
      repeat (LAT - 2) begin cyc(); chk("s1_not_yet", 16'(irq_out), 16'h0); end
      cyc();
      chk("s1_irq_out", 16'(irq_out), 16'h1);
      chk("s1_irq_id", 16'(irq_id), 16'h0);
      bus_read(3'd0);
      chk("s1_pending", readdata, 16'h0001);
      bus_write(3'd3, 16'h0000);
      chk("s1_ack_out", 16'(irq_out), 16'h0);
      bus_read(3'd0);
      chk("s1_pending_clr", readdata, 16'h0000);

      // RAW register follows the (possibly synchronized) input
      irq_in = 8'h80;
      bus_read(3'd4);
      chk("raw_first", readdata, (LAT == 2) ? 16'h0080 : 16'h0000);
      cyc(); cyc();
      bus_read(3'd4);
      chk("raw_settled", readdata, 16'h0080);
      irq_in = 0;
      repeat (3) cyc();

      // Scenario 2: level sources, priority and re-service after ACK
      bus_write(3'd2, 16'h0000);
      bus_write(3'd1, 16'h00FF);
      irq_in = 8'h24;
      repeat (LAT) cyc();
      chk("s2_out", 16'(irq_out), 16'h1);
      chk("s2_id2", 16'(irq_id), 16'h2);
      bus_write(3'd3, 16'h1234);
      chk("s2_ack_out", 16'(irq_out), 16'h0);
      cyc(); cyc();
      chk("s2_reserv_out", 16'(irq_out), 16'h1);
      chk("s2_reserv_id", 16'(irq_id), 16'h2);
      irq_in = 8'h20;
      repeat (LAT + 1) cyc();
      chk("s2_id5", 16'(irq_id), 16'h5);
      chk("s2_out5", 16'(irq_out), 16'h1);
      bus_write(3'd3, 16'h0000);
      cyc(); cyc();
      chk("s2_id5_again", 16'(irq_id), 16'h5);
      irq_in = 0;
      repeat (LAT + 2) cyc();
      chk("s2_idle", 16'(irq_out), 16'h0);

      // Scenario 3: edge set collides with W1C
      bus_write(3'd1, 16'h0000);
      bus_write(3'd2, 16'h00FF);
      bus_read(3'd0);
      chk("s3_switch_no_event", readdata, 16'h0000);
      irq_in = 8'h08;
      repeat (LAT - 2) cyc();
      bus_write(3'd0, 16'h0008);
      bus_read(3'd0);
      chk("s3_set_wins", readdata, 16'h0008);
      irq_in = 0;
      bus_write(3'd0, 16'h0008);
      bus_read(3'd0);
      chk("s3_w1c", readdata, 16'h0000);

      // Scenario 4: mask withdraws the source in service
      bus_write(3'd1, 16'h0002);
      irq_in = 8'h02; cyc(); irq_in = 0;
      repeat (LAT - 1) cyc();
      chk("s4_out", 16'(irq_out), 16'h1);
      chk("s4_id", 16'(irq_id), 16'h1);
      bus_write(3'd1, 16'h0000);
      cyc();
      chk("s4_withdrawn", 16'(irq_out), 16'h0);
      bus_read(3'd0);
      chk("s4_pending_kept", readdata, 16'h0002);

      // Scenario 5: reset during service
      bus_write(3'd1, 16'h0002);
      cyc();
      chk("s5_out", 16'(irq_out), 16'h1);
      reset = 1; cyc(); reset = 0;
      chk("s5_rst_out", 16'(irq_out), 16'h0);
      chk("s5_rst_id", 16'(irq_id), 16'h0);
      chk("s5_rst_rd", readdata, 16'h0000);
      bus_read(3'd0);
      chk("s5_rst_pending", readdata, 16'h0000);
      bus_read(3'd1);
      chk("s5_rst_mask", readdata, 16'h0000);

      // Randomized traffic against the model
      for (int n = 0; n < 800; n++) begin
         reset      = ($urandom_range(0, 149) == 0);
         chipselect = ($urandom_range(0, 2) != 0);
         write_n    = ($urandom_range(0, 1) == 0);
         address    = 3'($urandom_range(0, 7));
         writedata  = 16'($urandom);
         if ($urandom_range(0, 3) == 0) irq_in = 8'($urandom);
         cyc();
      end
      reset = 0; chipselect = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
